// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity-type constants and
// default widths used by the transmitter and its interface.
package uart_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int PRESCALE_WIDTH = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Request/line bundle between the TX data source and the UART transmitter.
interface uart_tx_if;

    logic [uart_pkg::DATA_WIDTH-1:0]     P_DATA;
    logic                                Data_Valid;
    logic                                PAR_EN;
    logic                                PAR_TYP;
    logic [uart_pkg::PRESCALE_WIDTH-1:0] prescale;
    logic                                TX_OUT;
    logic                                busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register for the UART transmitter: parallel load, LSB-first
// shift and a bit counter flagging the last payload bit.
module uart_tx_serializer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shift_d   = load_data;
            bit_cnt_d = '0;
        end else if (shift) begin
            shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ser_data = shift_q[0];
    assign ser_done = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one
// stop bit, each held for a latched prescale count; registered line and busy.
module uart_tx
    import uart_pkg::*;
(
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave tx_if
);

    tx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_m1_q, presc_m1_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic                      tx_out_q, tx_out_d;
    logic                      busy_q, busy_d;

    logic last_cycle, accept, ser_shift, ser_data, ser_done;

    assign last_cycle = (edge_cnt_q == presc_m1_q);
    assign accept     = tx_if.Data_Valid &&
                        (state_q == TX_IDLE || (state_q == TX_STOP && last_cycle));
    assign ser_shift  = (state_q == TX_DATA) && last_cycle;

    uart_tx_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (ser_shift),
        .load_data (tx_if.P_DATA),
        .ser_data  (ser_data),
        .ser_done  (ser_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        presc_m1_d = presc_m1_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;

        if (accept) begin
            edge_cnt_d = '0;
            // A prescale of 0 behaves as 1, so the terminal count stays at 0.
            presc_m1_d = (tx_if.prescale == '0) ? '0 : tx_if.prescale - 1'b1;
            par_en_d   = tx_if.PAR_EN;
            par_bit_d  = (^tx_if.P_DATA) ^ (tx_if.PAR_TYP == PAR_ODD);
        end else if (state_q != TX_IDLE) begin
            edge_cnt_d = last_cycle ? '0 : edge_cnt_q + 1'b1;
        end

        case (state_q)
            TX_IDLE:   if (accept) state_d = TX_START;
            TX_START:  if (last_cycle) state_d = TX_DATA;
            TX_DATA:   if (last_cycle && ser_done) state_d = par_en_q ? TX_PARITY : TX_STOP;
            TX_PARITY: if (last_cycle) state_d = TX_STOP;
            TX_STOP:   if (last_cycle) state_d = accept ? TX_START : TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    // Line and busy follow the current state one clock later.
    always_comb begin
        tx_out_d = 1'b1;
        busy_d   = (state_q != TX_IDLE);
        case (state_q)
            TX_START:  tx_out_d = 1'b0;
            TX_DATA:   tx_out_d = ser_data;
            TX_PARITY: tx_out_d = par_bit_q;
            default:   tx_out_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            edge_cnt_q <= '0;
            presc_m1_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            presc_m1_q <= presc_m1_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, parity, back-to-back
// frames, ignored mid-frame requests and asynchronous reset.
module tb_uart_tx;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_tx_if tx_if ();

    uart_tx dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line bits in transmit order: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] data, input logic par_en,
                                               input logic par_typ);
        logic [10:0] f;
        f        = '1;
        f[0]     = 1'b0;
        f[8:1]   = data;
        if (par_en) f[9] = (^data) ^ par_typ;
        return f;
    endfunction

    // Sends one frame from IDLE and checks every cycle of the line and busy.
    task automatic test_frame(input string name, input logic [7:0] data, input logic par_en,
                              input logic par_typ, input int presc);
        logic [10:0] f;
        int          nbits;
        f     = frame_bits(data, par_en, par_typ);
        nbits = par_en ? 11 : 10;
        @(posedge clk); #1;
        tx_if.P_DATA     = data;
        tx_if.PAR_EN     = par_en;
        tx_if.PAR_TYP    = par_typ;
        tx_if.prescale   = 6'(presc);
        tx_if.Data_Valid = 1'b1;
        @(posedge clk); #1;
        tx_if.Data_Valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pre_start: line=%b busy=%b required line=1 busy=0",
                     name, tx_if.TX_OUT, tx_if.busy);
        end
        for (int i = 0; i < nbits * presc; i++) begin
            @(negedge clk);
            total++;
            if (tx_if.TX_OUT !== f[i / presc] || tx_if.busy !== 1'b1) begin
                bad++;
                $display("FAIL %s cycle %0d: line=%b busy=%b required line=%b busy=1",
                         name, i, tx_if.TX_OUT, tx_if.busy, f[i / presc]);
            end
        end
        @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end: line=%b busy=%b required line=1 busy=0",
                     name, tx_if.TX_OUT, tx_if.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: line=%b busy=%b required line=1 busy=0",
                     tx_if.TX_OUT, tx_if.busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: line=%b busy=%b required line=1 busy=0",
                     tx_if.TX_OUT, tx_if.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        logic        exp;
        f1 = frame_bits(8'h3C, 1'b0, 1'b0);
        f2 = frame_bits(8'hC3, 1'b0, 1'b0);
        @(posedge clk); #1;
        tx_if.P_DATA     = 8'h3C;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd4;
        tx_if.Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            exp = (i < 40) ? f1[i / 4] : f2[(i - 40) / 4];
            total++;
            if (tx_if.TX_OUT !== exp || tx_if.busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b cycle %0d: line=%b busy=%b required line=%b busy=1",
                         i, tx_if.TX_OUT, tx_if.busy, exp);
            end
            // New byte presented for the last STOP cycle, withdrawn right after its accept.
            if (i == 38) tx_if.P_DATA = 8'hC3;
            if (i == 39) tx_if.Data_Valid = 1'b0;
        end
        @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b end: line=%b busy=%b required line=1 busy=0",
                     tx_if.TX_OUT, tx_if.busy);
        end
    endtask

    task automatic test_mid_frame_ignore();
        logic [10:0] f;
        f = frame_bits(8'h5A, 1'b0, 1'b0);
        @(posedge clk); #1;
        tx_if.P_DATA     = 8'h5A;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd2;
        tx_if.Data_Valid = 1'b1;
        @(posedge clk); #1;
        tx_if.Data_Valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (tx_if.TX_OUT !== f[i / 2] || tx_if.busy !== 1'b1) begin
                bad++;
                $display("FAIL ignore cycle %0d: line=%b busy=%b required line=%b busy=1",
                         i, tx_if.TX_OUT, tx_if.busy, f[i / 2]);
            end
            if (i == 6) begin
                tx_if.P_DATA     = 8'h00;
                tx_if.Data_Valid = 1'b1;
            end
            if (i == 7) tx_if.Data_Valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL ignore idle %0d: line=%b busy=%b required line=1 busy=0",
                         i, tx_if.TX_OUT, tx_if.busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        tx_if.P_DATA     = 8'hA5;
        tx_if.PAR_EN     = 1'b1;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd4;
        tx_if.Data_Valid = 1'b1;
        @(posedge clk); #1;
        tx_if.Data_Valid = 1'b0;
        @(negedge clk);
        repeat (11) @(negedge clk);
        // Frame bit 2 (data bit 1 of 0xA5) is a 0 on the line here.
        total++;
        if (tx_if.TX_OUT !== 1'b0 || tx_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid pre: line=%b busy=%b required line=0 busy=1",
                     tx_if.TX_OUT, tx_if.busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid async: line=%b busy=%b required line=1 busy=0",
                     tx_if.TX_OUT, tx_if.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid idle %0d: line=%b busy=%b required line=1 busy=0",
                         i, tx_if.TX_OUT, tx_if.busy);
            end
        end
        test_frame("after_reset", 8'h96, 1'b1, 1'b1, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total            = 0;
        bad              = 0;
        tx_if.P_DATA     = '0;
        tx_if.Data_Valid = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd1;
        test_reset();
        test_frame("a5_even_p8", 8'hA5, 1'b1, 1'b0, 8);
        test_frame("01_odd_p1", 8'h01, 1'b1, 1'b1, 1);
        test_frame("ff_nopar_p16", 8'hFF, 1'b0, 1'b0, 16);
        test_frame("presc0_as_1", 8'h6E, 1'b0, 1'b0, 0 + 1);
        test_back_to_back();
        test_mid_frame_ignore();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one parallel byte per accepted request into a start bit, 8 data bits (LSB first), an optional parity bit and one stop bit on a single serial line. Each bit is held for `prescale` clock cycles, matching the oversampling ratio used by the receive path. The block sits in the UART TX clock domain, is fed by the data synchroniser/FIFO read side, and drives the serial pin.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 6: width of the `prescale` input.
- `clk`  in  1  transmitter clock.
- `rst`  in  1  asynchronous reset, active-high.
- `P_DATA`  in  DATA_WIDTH  byte to send, sampled on accept.
- `Data_Valid`  in  1  transmit request; accepted per the handshake rules below.
- `PAR_EN`  in  1  1 = insert a parity bit; sampled on accept.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on accept.
- `prescale`  in  PRESCALE_WIDTH  clock cycles per bit, legal 1..32, 0 treated as 1; sampled on accept.
- `TX_OUT`  out  1  serial line, registered, idle high.
- `busy`  out  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding lives in the shared package.
- **Accept**: a rising `clk` edge with `Data_Valid`=1 in either of two cases:
  - in IDLE;
  - in STOP on its last bit cycle.
- At accept, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale` into internal registers.
- At accept, compute the parity bit from the latched data:
  - even: XOR of all 8 bits;
  - odd: inverse of that XOR.
- `Data_Valid` at any other time is ignored. It has no effect on the frame in flight.
- Bit timer: `edge_cnt` counts 0..prescale-1. "Last cycle" means `edge_cnt` == prescale-1.
- `bit_cnt` counts 0..7 in DATA.
- Transitions:
  - IDLE to START on accept.
  - START to DATA on last cycle.
  - DATA stays in DATA until the last cycle with `bit_cnt`==7. It then goes to PARITY if latched `PAR_EN`, else to STOP.
  - PARITY to STOP on last cycle.
  - STOP on last cycle: to START on accept, else to IDLE.
- Line value per state:
  - IDLE 1;
  - START 0;
  - DATA shows the shift-register LSB, and the register shifts right on each last cycle;
  - PARITY shows the parity bit;
  - STOP 1.
- `busy` is 1 in every state except IDLE.
- Reset (any time, including mid-frame) gives: state IDLE, `TX_OUT`=1, `busy`=0, counters 0, shift register 0. No partial frame resumes after reset is released.

## Timing
- `TX_OUT` and `busy` are registered. Both change on the clock edge after the accept edge, so the start bit begins 1 cycle after accept.
- Each bit occupies exactly prescale cycles on the line.
- Frame length is 10×prescale cycles without parity and 11×prescale cycles with parity.
- Back-to-back frames: accepting in the last STOP cycle makes the next start bit follow the stop bit with zero idle cycles. `busy` stays high throughout.
- Minimum IDLE dwell with no back-to-back request: 1 cycle. `busy` falls the cycle after the last STOP cycle.
- Reset is asynchronous. Outputs reach their reset values without waiting for a clock edge.

## Structure
- Shared `uart_pkg` holds:
  - the state encoding for TX;
  - the parity-type constants (EVEN=0, ODD=1);
  - `DATA_WIDTH` and `PRESCALE_WIDTH` defaults.
- One sub-module, `uart_tx_serializer`:
  - load and shift register;
  - `bit_cnt`;
  - exposes `ser_data` and `ser_done`.
- The top holds the FSM, the `edge_cnt` timer, parity computation and the output mux/register.

## Test plan
- prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5:
  - line 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles;
  - `busy` high for 88 cycles.
- prescale=1, PAR_EN=1, PAR_TYP=1, P_DATA=0x01:
  - line 0,1,0,0,0,0,0,0,0,0,1 over 11 cycles.
- prescale=16, PAR_EN=0, P_DATA=0xFF:
  - start 16 cycles low, then 144 cycles high;
  - `busy` high for 160 cycles.
- Back-to-back, prescale=4, PAR_EN=0:
  - hold `Data_Valid`=1 with 0x3C, then change to 0xC3 at the last STOP cycle;
  - two frames with no idle gap, `busy` continuously high for 80 cycles.
- Mid-frame ignore:
  - pulse `Data_Valid` with 0x00 during DATA of a 0x5A frame;
  - frame 0x5A completes unchanged, then returns to IDLE.
- Reset mid-frame:
  - assert `rst` during the DATA state;
  - `TX_OUT`=1 and `busy`=0 immediately;
  - the next accept after release produces a clean full frame.
